// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes a word-wide bitstream LSB-first into a
// fabric CCFF chain and, in verify mode, checks the chain tail against the same stream.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 68,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_bit_idx
);

    localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               mode;
    logic [WORD_W-1:0]  word_sr;
    logic [WCNT_W-1:0]  word_cnt;
    logic [IDX_W-1:0]   bit_cnt;
    logic               mismatch;

    // The chain sees bit 0 of the shift register directly; it is a flop output,
    // so the head changes only on prog_clk edges.
    assign ccff_head = word_sr[0];
    assign mismatch  = mode && (ccff_tail != word_sr[0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cfg_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = DONE;
                end else if (word_cnt == LAST_WBIT) begin
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status and chain-control outputs are decoded from the next state and
    // registered, so the external prog_clk gate sees a clean enable.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state         <= IDLE;
            cfg_ready     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cfg_ready     <= (state_nxt == FETCH);
            ccff_shift_en <= (state_nxt == SHIFT);
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
        end
    end

    // Datapath: word capture, serialization counters and the verify comparator.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            mode        <= 1'b0;
            word_sr     <= '0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            error       <= 1'b0;
            err_bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode        <= verify;
                        bit_cnt     <= '0;
                        error       <= 1'b0;
                        err_bit_idx <= '0;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        word_sr  <= cfg_data;
                        word_cnt <= '0;
                    end
                end
                SHIFT: begin
                    word_sr <= word_sr >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (word_cnt != LAST_WBIT) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                    if (mismatch) begin
                        error <= 1'b1;
                        if (!error) begin
                            err_bit_idx <= bit_cnt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: drives load/verify passes into a
// behavioural 68-FF chain and checks handshakes, shift counts and chain contents.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 68;
    localparam int WORD_W    = 32;
    localparam int IDX_W     = $clog2(CHAIN_LEN + 1);

    localparam logic [31:0] W0   = 32'hA5A51234;
    localparam logic [31:0] W1   = 32'h0F0FF0F0;
    localparam logic [31:0] W2   = 32'h0000000B;
    localparam logic [31:0] W1_C = 32'h0F0FF1F0;
    localparam logic [31:0] W2_T = 32'hFFFFFFF5;
    localparam logic [CHAIN_LEN-1:0] EXP_LOAD  = 68'hB_0F0FF0F0_A5A51234;
    localparam logic [CHAIN_LEN-1:0] EXP_TRUNC = 68'h5_0F0FF0F0_A5A51234;

    logic              prog_clk  = 1'b0;
    logic              pReset    = 1'b0;
    logic              start     = 1'b0;
    logic              verify    = 1'b0;
    logic [WORD_W-1:0] cfg_data  = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              error;
    logic [IDX_W-1:0]  err_bit_idx;

    logic [CHAIN_LEN-1:0] chain;

    int cmp_cnt = 0;
    int err_cnt = 0;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .verify        (verify),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_bit_idx   (err_bit_idx)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: a FIFO clocked by the gated prog_clk; the oldest bit sits at chain[0].
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
        end
    end
    assign ccff_tail = chain[0];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("[TB] %s differs", tag);
        end
    endtask

    // One full pass. Inputs change on the falling edge and outputs are sampled there too.
    // gap holds cfg_valid low for that many ready cycles after each accepted word;
    // stray_start raises start for one cycle at that loop index (-1 for none).
    task automatic apply_stimulus(input logic vmode, input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input int gap, input int stray_start,
                                  output int cycles, output int shifts, output int hs,
                                  output int dones, output logic [2:0] first_flags,
                                  output int bad_cycles);
        logic [31:0] words [3];
        int widx;
        int gap_left;
        bit finished;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        cycles = 0; shifts = 0; hs = 0; dones = 0; bad_cycles = 0;
        first_flags = '0; widx = 0; gap_left = 0; finished = 0;
        @(negedge prog_clk);
        start = 1'b1; verify = vmode; cfg_valid = 1'b1; cfg_data = w0;
        cycles = 1;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge prog_clk);
            cycles++;
            start = (i == stray_start);
            if (i == 0) first_flags = {cfg_ready, busy, error};
            if (ccff_shift_en) shifts++;
            if ((ccff_shift_en && cfg_ready) || !busy) bad_cycles++;
            if (done) begin
                dones++;
                finished = 1;
            end
            if (!finished && widx < 3 && gap_left == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = words[widx];
            end else begin
                cfg_valid = 1'b0;
                if (cfg_ready && gap_left > 0) gap_left--;
            end
            if (cfg_valid && cfg_ready) begin
                hs++;
                widx++;
                gap_left = gap;
            end
        end
        start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        if (done) dones++;
    endtask

    int cyc, sh, hs, dn, bad, nshift;
    logic [2:0] ff;
    logic [31:0] w0_v;
    bit found;

    initial begin
        // Reset values
        repeat (3) @(negedge prog_clk);
        check_output("reset_outputs",
                     {cfg_ready, ccff_head, ccff_shift_en, busy, done, error, err_bit_idx}, '0);
        pReset = 1'b1;
        repeat (2) @(negedge prog_clk);

        // Plain load
        apply_stimulus(1'b0, W0, W1, W2, 0, -1, cyc, sh, hs, dn, ff, bad);
        check_output("load_cycles", cyc, 73);
        check_output("load_shifts", sh, 68);
        check_output("load_handshakes", hs, 3);
        check_output("load_done_pulses", dn, 1);
        check_output("load_first_cycle_flags", ff, 3'b110);
        check_output("load_bad_cycles", bad, 0);
        check_output("load_chain", chain, EXP_LOAD);
        check_output("load_error", error, 1'b0);

        // Clean verify
        apply_stimulus(1'b1, W0, W1, W2, 0, -1, cyc, sh, hs, dn, ff, bad);
        check_output("verify_clean_error", {error, err_bit_idx}, '0);
        check_output("verify_clean_chain", chain, EXP_LOAD);
        check_output("verify_clean_done", dn, 1);
        check_output("verify_clean_shifts", sh, 68);

        // Corrupted verify: stream bit 40 flipped
        apply_stimulus(1'b1, W0, W1_C, W2, 0, -1, cyc, sh, hs, dn, ff, bad);
        check_output("verify_bad_error_idx", {error, err_bit_idx}, {1'b1, 7'd40});
        check_output("verify_bad_done", dn, 1);
        repeat (2) @(negedge prog_clk);
        check_output("verify_bad_error_sticky", {error, err_bit_idx}, {1'b1, 7'd40});

        // Backpressure load; the start also clears the sticky error
        apply_stimulus(1'b0, W0, W1, W2, 5, -1, cyc, sh, hs, dn, ff, bad);
        check_output("bp_first_cycle_flags", ff, 3'b110);
        check_output("bp_cycles", cyc, 83);
        check_output("bp_shifts", sh, 68);
        check_output("bp_handshakes", hs, 3);
        check_output("bp_bad_cycles", bad, 0);
        check_output("bp_chain", chain, EXP_LOAD);

        // Truncated last word, stray start during SHIFT
        apply_stimulus(1'b0, W0, W1, W2_T, 0, 10, cyc, sh, hs, dn, ff, bad);
        check_output("trunc_cycles", cyc, 73);
        check_output("trunc_shifts", sh, 68);
        check_output("trunc_done_pulses", dn, 1);
        check_output("trunc_top_bits", chain[67:64], 4'b0101);
        check_output("trunc_chain", chain, EXP_TRUNC);

        // Reset while bit 20 is on the head
        w0_v = W0;
        @(negedge prog_clk);
        start = 1'b1; verify = 1'b0; cfg_valid = 1'b1; cfg_data = W0;
        @(negedge prog_clk);
        start = 1'b0;
        nshift = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (ccff_shift_en) nshift++;
            if (nshift == 21) found = 1;
            else @(negedge prog_clk);
        end
        check_output("midreset_reached_bit20", found, 1'b1);
        check_output("midreset_head_bit20", ccff_head, w0_v[20]);
        pReset = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check_output("midreset_outputs",
                     {cfg_ready, ccff_head, ccff_shift_en, busy, done, error, err_bit_idx}, '0);
        repeat (2) @(negedge prog_clk);
        check_output("midreset_held", {busy, done, ccff_shift_en}, 3'b000);
        pReset = 1'b1;
        @(negedge prog_clk);
        apply_stimulus(1'b0, W0, W1, W2, 0, -1, cyc, sh, hs, dn, ff, bad);
        check_output("postreset_cycles", cyc, 73);
        check_output("postreset_shifts", sh, 68);
        check_output("postreset_chain", chain, EXP_LOAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
